// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-to-AXI bridge: FSM encodings,
// AXI ID assignments and the latched request record.
package cpu_axi_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_B    = 2'd2
    } w_state_t;

    localparam logic [3:0] INST_ID = 4'd0;
    localparam logic [3:0] DATA_ID = 4'd1;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sram_req_t;

    function automatic logic [2:0] ax_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/cpu_axi_bridge_axi_wr_ch.sv
// Single-outstanding AXI write channel: AW and W are raised together and each
// retires on its own handshake; the B response produces one completion pulse.
module axi_wr_ch
    import cpu_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        accept,
    input  sram_req_t   req,
    output logic        idle,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready,
    output logic        done
);

    w_state_t state;

    assign idle = (state == W_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= W_IDLE;
            awaddr  <= '0;
            awsize  <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wstrb   <= '0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                W_IDLE: begin
                    if (accept) begin
                        state   <= W_REQ;
                        awaddr  <= req.addr;
                        awsize  <= ax_size(req.size);
                        wdata   <= req.wdata;
                        wstrb   <= req.wstrb;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end
                end
                W_REQ: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    // Both channels are finished once each has either already
                    // handshaken or is handshaking on this edge.
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        state  <= W_B;
                        bready <= 1'b1;
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        state  <= W_IDLE;
                        bready <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI master
// with one outstanding read (data-over-inst priority) and one outstanding write.
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    r_state_t  rstate;
    logic      r_idle;
    logic      w_idle;
    logic      wr_done;
    logic      data_rd_req;
    logic      data_rd_acc;
    logic      data_wr_acc;
    logic      inst_acc;
    logic      inst_rd_ok;
    logic      data_rd_ok;
    sram_req_t data_req_s;
    logic      unused_inputs;

    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awid    = DATA_ID;
    assign wid     = DATA_ID;
    assign wlast   = 1'b1;

    // Instruction port is read-only; responses are single-beat and always OKAY-agnostic.
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             rid[3:1], rresp, rlast, bid, bresp};

    // A data read waits for the write side to drain so it never overtakes a store.
    assign r_idle      = (rstate == R_IDLE);
    assign data_rd_req = data_sram_req && !data_sram_wr;
    assign data_rd_acc = data_rd_req && r_idle && w_idle;
    assign data_wr_acc = data_sram_req && data_sram_wr && w_idle;
    assign inst_acc    = inst_sram_req && r_idle && !data_rd_req;

    assign inst_sram_addr_ok = inst_acc;
    assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
    assign inst_sram_data_ok = inst_rd_ok;
    assign data_sram_data_ok = data_rd_ok || wr_done;

    assign data_req_s = '{addr:  data_sram_addr,
                          size:  data_sram_size,
                          wstrb: data_sram_wstrb,
                          wdata: data_sram_wdata};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate          <= R_IDLE;
            arid            <= '0;
            araddr          <= '0;
            arsize          <= '0;
            arvalid         <= 1'b0;
            rready          <= 1'b0;
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
            inst_rd_ok      <= 1'b0;
            data_rd_ok      <= 1'b0;
        end else begin
            inst_rd_ok <= 1'b0;
            data_rd_ok <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    if (data_rd_acc) begin
                        rstate  <= R_AR;
                        arid    <= DATA_ID;
                        araddr  <= data_sram_addr;
                        arsize  <= ax_size(data_sram_size);
                        arvalid <= 1'b1;
                    end else if (inst_acc) begin
                        rstate  <= R_AR;
                        arid    <= INST_ID;
                        araddr  <= inst_sram_addr;
                        arsize  <= ax_size(inst_sram_size);
                        arvalid <= 1'b1;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        rstate  <= R_R;
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                R_R: begin
                    if (rvalid) begin
                        rstate <= R_IDLE;
                        rready <= 1'b0;
                        if (rid[0]) begin
                            data_sram_rdata <= rdata;
                            data_rd_ok      <= 1'b1;
                        end else begin
                            inst_sram_rdata <= rdata;
                            inst_rd_ok      <= 1'b1;
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    axi_wr_ch u_wr_ch (
        .clk     (clk),
        .resetn  (resetn),
        .accept  (data_wr_acc),
        .req     (data_req_s),
        .idle    (w_idle),
        .awaddr  (awaddr),
        .awsize  (awsize),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bvalid  (bvalid),
        .bready  (bready),
        .done    (wr_done)
    );

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: an AXI slave with programmable delays,
// a transaction-level model checked every cycle, and literal spot checks.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_tests = 0;
    int n_fail  = 0;
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;

    cpu_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h1C00_0000) ? 32'h0280_0421 : (a ^ 32'h5A5A_5A5A);
    endfunction

    // Transaction-level model: which transfer is outstanding and in which phase.
    logic        m_ar = 0, m_r = 0, m_aw = 0, m_w = 0, m_b = 0;
    logic [31:0] m_araddr = 0, m_awaddr = 0, m_wdata = 0;
    logic [3:0]  m_arid = 0, m_wstrb = 0;
    logic [2:0]  m_arsize = 0, m_awsize = 0;
    logic        m_iok = 0, m_dok = 0;
    logic [31:0] m_irdata = 0, m_drdata = 0;

    function automatic logic f_inst_ok();
        return inst_sram_req && !(m_ar || m_r) && !(data_sram_req && !data_sram_wr);
    endfunction

    function automatic logic f_data_ok();
        logic wbusy;
        wbusy = m_aw || m_w || m_b;
        if (!data_sram_req) return 1'b0;
        if (data_sram_wr) return !wbusy;
        return !wbusy && !(m_ar || m_r);
    endfunction

    always @(posedge clk or negedge resetn) begin : model
        logic ai, ad;
        if (!resetn) begin
            m_ar = 0; m_r = 0; m_aw = 0; m_w = 0; m_b = 0;
            m_iok = 0; m_dok = 0; m_irdata = 0; m_drdata = 0;
        end else begin
            ai = f_inst_ok();
            ad = f_data_ok();
            m_iok = 0;
            m_dok = 0;
            if (m_r) begin
                if (rvalid) begin
                    m_r = 0;
                    if (rid[0]) begin m_drdata = rdata; m_dok = 1; end
                    else        begin m_irdata = rdata; m_iok = 1; end
                end
            end else if (m_ar) begin
                if (arready) begin m_ar = 0; m_r = 1; end
            end else if (ad && !data_sram_wr) begin
                m_ar = 1; m_araddr = data_sram_addr; m_arid = 4'd1; m_arsize = {1'b0, data_sram_size};
            end else if (ai) begin
                m_ar = 1; m_araddr = inst_sram_addr; m_arid = 4'd0; m_arsize = {1'b0, inst_sram_size};
            end
            if (m_b) begin
                if (bvalid) begin m_b = 0; m_dok = 1; end
            end else if (m_aw || m_w) begin
                if (awready) m_aw = 0;
                if (wready)  m_w  = 0;
                if (!m_aw && !m_w) m_b = 1;
            end else if (ad && data_sram_wr) begin
                m_aw = 1; m_w = 1;
                m_awaddr = data_sram_addr; m_awsize = {1'b0, data_sram_size};
                m_wdata = data_sram_wdata; m_wstrb = data_sram_wstrb;
            end
        end
    end

    always @(negedge clk) begin : cmp
        chk("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(f_inst_ok()));
        chk("data_addr_ok", 32'(data_sram_addr_ok), 32'(f_data_ok()));
        chk("arvalid", 32'(arvalid), 32'(m_ar));
        if (m_ar) begin
            chk("araddr", araddr, m_araddr);
            chk("arid", 32'(arid), 32'(m_arid));
            chk("arsize", 32'(arsize), 32'(m_arsize));
        end
        chk("rready", 32'(rready), 32'(m_r));
        chk("awvalid", 32'(awvalid), 32'(m_aw));
        if (m_aw) begin
            chk("awaddr", awaddr, m_awaddr);
            chk("awsize", 32'(awsize), 32'(m_awsize));
        end
        chk("wvalid", 32'(wvalid), 32'(m_w));
        if (m_w) begin
            chk("wdata", wdata, m_wdata);
            chk("wstrb", 32'(wstrb), 32'(m_wstrb));
        end
        chk("bready", 32'(bready), 32'(m_b));
        chk("inst_data_ok", 32'(inst_sram_data_ok), 32'(m_iok));
        chk("data_data_ok", 32'(data_sram_data_ok), 32'(m_dok));
        chk("inst_rdata", inst_sram_rdata, m_irdata);
        chk("data_rdata", data_sram_rdata, m_drdata);
    end

    initial begin : rd_slave
        int ar_cnt, r_cnt;
        bit ar_hs, r_pend;
        logic [31:0] a;
        logic [3:0] id;
        ar_cnt = 0; r_cnt = 0; ar_hs = 0; r_pend = 0; a = 0; id = 0;
        arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
        forever begin
            @(posedge clk); #1;
            rvalid = 0; rlast = 0;
            if (!resetn) begin
                arready = 0; ar_cnt = 0; ar_hs = 0; r_pend = 0;
                continue;
            end
            if (ar_hs) begin
                ar_hs = 0; arready = 0; r_pend = 1; r_cnt = 0;
            end else if (arvalid) begin
                if (ar_cnt >= ar_wait) begin
                    arready = 1; ar_hs = 1; ar_cnt = 0; a = araddr; id = arid;
                end else ar_cnt++;
            end
            if (r_pend) begin
                if (r_cnt >= r_wait) begin
                    rvalid = 1; rlast = 1; rid = id; rdata = mem_rd(a); r_pend = 0;
                end else r_cnt++;
            end
        end
    end

    initial begin : wr_slave
        int aw_cnt, w_cnt, b_cnt;
        bit aw_hs, w_hs, aw_done, w_done;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_hs = 0; w_hs = 0; aw_done = 0; w_done = 0;
        awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
        forever begin
            @(posedge clk); #1;
            bvalid = 0;
            if (!resetn) begin
                awready = 0; wready = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                aw_hs = 0; w_hs = 0; aw_done = 0; w_done = 0;
                continue;
            end
            if (aw_hs) begin
                aw_hs = 0; awready = 0; aw_done = 1;
            end else if (awvalid && !aw_done) begin
                if (aw_cnt >= aw_wait) begin awready = 1; aw_hs = 1; aw_cnt = 0; end
                else aw_cnt++;
            end
            if (w_hs) begin
                w_hs = 0; wready = 0; w_done = 1;
            end else if (wvalid && !w_done) begin
                if (w_cnt >= w_wait) begin wready = 1; w_hs = 1; w_cnt = 0; end
                else w_cnt++;
            end
            if (aw_done && w_done) begin
                if (b_cnt >= b_wait) begin
                    bvalid = 1; bid = 4'd1; aw_done = 0; w_done = 0; b_cnt = 0;
                end else b_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic run(input int n, output int dok, output int iok, output int arv);
        dok = 0; iok = 0; arv = 0;
        repeat (n) begin
            @(negedge clk);
            dok += int'(data_sram_data_ok);
            iok += int'(inst_sram_data_ok);
            arv += int'(arvalid);
            step();
        end
    endtask

    task automatic idle_reqs();
        inst_sram_req = 0; data_sram_req = 0; data_sram_wr = 0;
    endtask

    initial begin : main
        int dok, iok, arv;
        resetn = 0;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0;
        data_sram_addr = 0; data_sram_wdata = 0;

        @(negedge clk);
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_awvalid", 32'(awvalid), 0);
        chk("rst_wvalid", 32'(wvalid), 0);
        chk("rst_rready", 32'(rready), 0);
        chk("rst_bready", 32'(bready), 0);
        chk("rst_data_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);
        chk("rst_rdata", inst_sram_rdata | data_sram_rdata, 0);
        step(); resetn = 1;
        step();
        chk("const_ar", {arlen, arburst, arlock, arcache, arprot, 15'd0}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 15'd0});
        chk("const_aw", {awlen, awburst, awlock, awcache, awprot, 15'd0}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 15'd0});
        chk("const_w", {awid, wid, 23'd0, wlast}, {4'd1, 4'd1, 23'd0, 1'b1});
        step();

        // Minimum-latency instruction fetch.
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2;
        @(negedge clk); chk("t1_addr_ok", 32'(inst_sram_addr_ok), 1);
        step(); inst_sram_req = 0;
        @(negedge clk);
        chk("t1_arvalid", 32'(arvalid), 1);
        chk("t1_araddr", araddr, 32'h1C00_0000);
        chk("t1_arid", 32'(arid), 0);
        chk("t1_arsize", 32'(arsize), 32'd2);
        step(); @(negedge clk); chk("t1_rready", 32'(rready), 1);
        step(); @(negedge clk);
        chk("t1_data_ok", 32'(inst_sram_data_ok), 1);
        chk("t1_rdata", inst_sram_rdata, 32'h0280_0421);
        step(); @(negedge clk); chk("t1_data_ok_drop", 32'(inst_sram_data_ok), 0);
        step(); step();

        // Simultaneous inst and data reads: data first, inst after R completes.
        inst_sram_req = 1; inst_sram_addr = 32'h100;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h200; data_sram_size = 2'd2;
        @(negedge clk);
        chk("t2_d_addr_ok", 32'(data_sram_addr_ok), 1);
        chk("t2_i_addr_ok", 32'(inst_sram_addr_ok), 0);
        step(); data_sram_req = 0;
        @(negedge clk);
        chk("t2_araddr", araddr, 32'h200);
        chk("t2_arid", 32'(arid), 1);
        chk("t2_i_blocked", 32'(inst_sram_addr_ok), 0);
        step(); @(negedge clk); chk("t2_i_blocked_r", 32'(inst_sram_addr_ok), 0);
        step(); @(negedge clk);
        chk("t2_i_addr_ok", 32'(inst_sram_addr_ok), 1);
        chk("t2_d_data_ok", 32'(data_sram_data_ok), 1);
        chk("t2_d_rdata", data_sram_rdata, 32'h5A5A_585A);
        step(); inst_sram_req = 0;
        @(negedge clk);
        chk("t2_araddr_i", araddr, 32'h100);
        chk("t2_arid_i", 32'(arid), 0);
        step(); step(); @(negedge clk);
        chk("t2_i_data_ok", 32'(inst_sram_data_ok), 1);
        chk("t2_i_rdata", inst_sram_rdata, 32'h5A5A_5B5A);
        step(); step();

        // Byte write with W accepted three cycles before AW.
        aw_wait = 3; w_wait = 0; b_wait = 0;
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd0; data_sram_wstrb = 4'b0100;
        data_sram_addr = 32'h8000_0010; data_sram_wdata = 32'h00AB_0000;
        @(negedge clk); chk("t3_addr_ok", 32'(data_sram_addr_ok), 1);
        step(); idle_reqs();
        @(negedge clk);
        chk("t3_awvalid", 32'(awvalid), 1);
        chk("t3_wvalid", 32'(wvalid), 1);
        chk("t3_awaddr", awaddr, 32'h8000_0010);
        chk("t3_awsize", 32'(awsize), 0);
        chk("t3_wstrb", 32'(wstrb), 32'h4);
        chk("t3_wdata", wdata, 32'h00AB_0000);
        step(); @(negedge clk);
        chk("t3_w_dropped", 32'(wvalid), 0);
        chk("t3_aw_held", 32'(awvalid), 1);
        step();
        run(6, dok, iok, arv);
        chk("t3_one_data_ok", 32'(dok), 1);
        aw_wait = 0;

        // Data read blocked while the write waits for B.
        b_wait = 3;
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd2; data_sram_wstrb = 4'hF;
        data_sram_addr = 32'h8000_0010; data_sram_wdata = 32'h1234_5678;
        step(); idle_reqs();
        step(); data_sram_req = 1; data_sram_wr = 0;
        @(negedge clk); chk("t4_blocked_c2", 32'(data_sram_addr_ok), 0);
        step(); step(); step();
        @(negedge clk); chk("t4_blocked_c5", 32'(data_sram_addr_ok), 0);
        step(); @(negedge clk);
        chk("t4_accept_c6", 32'(data_sram_addr_ok), 1);
        chk("t4_wr_data_ok", 32'(data_sram_data_ok), 1);
        step(); idle_reqs();
        run(4, dok, iok, arv);
        chk("t4_rd_data_ok", 32'(dok), 1);
        chk("t4_rdata", data_sram_rdata, 32'hDA5A_5A4A);
        b_wait = 0;

        // Slow AR and R: arvalid held, one completion.
        ar_wait = 5; r_wait = 4;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h40;
        @(negedge clk); chk("t5_addr_ok", 32'(data_sram_addr_ok), 1);
        step(); idle_reqs();
        run(14, dok, iok, arv);
        chk("t5_arvalid_cycles", 32'(arv), 32'd6);
        chk("t5_one_data_ok", 32'(dok), 1);
        chk("t5_rdata", data_sram_rdata, 32'h5A5A_5A1A);

        // Reset while waiting for R abandons the fetch.
        ar_wait = 0; r_wait = 3;
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000;
        step(); idle_reqs();
        step(); @(negedge clk); chk("t6_in_r", 32'(rready), 1);
        step(); resetn = 0;
        @(negedge clk);
        chk("t6_rready_rst", 32'(rready), 0);
        chk("t6_arvalid_rst", 32'(arvalid), 0);
        chk("t6_irdata_rst", inst_sram_rdata, 0);
        step();
        step(); resetn = 1; r_wait = 0;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h300;
        @(negedge clk); chk("t6_first_accept", 32'(data_sram_addr_ok), 1);
        step(); idle_reqs();
        run(6, dok, iok, arv);
        chk("t6_d_data_ok", 32'(dok), 1);
        chk("t6_no_inst_ok", 32'(iok), 0);
        chk("t6_rdata", data_sram_rdata, 32'h5A5A_595A);

        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
